// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module  : async_fifo_pkg
// Brief   : Shared types and helpers for the async FIFO write-side arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_arb_state_e;

    localparam int NREQ_DEF      = 4;
    localparam int MAX_BURST_DEF = 4;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int ID_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin search: first set bit at or after start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import async_fifo_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]       req,
    input  logic [ID_W(NREQ)-1:0] start,
    output logic                  found,
    output logic [ID_W(NREQ)-1:0] idx
);

    localparam int IW = ID_W(NREQ);

    // Walk the ring backwards so the candidate closest to start wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + k) % NREQ);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin burst arbiter sharing the async FIFO write port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic                    gnt_active,
    output logic [ID_W(NREQ)-1:0]   gnt_id
);

    localparam int             IW        = ID_W(NREQ);
    localparam int             CW        = ID_W(MAX_BURST);
    localparam logic [IW-1:0]  LAST_ID   = IW'(NREQ - 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    wr_arb_state_e   r_state,    w_state;
    logic [IW-1:0]   r_gnt_id,   w_gnt_id;
    logic [CW-1:0]   r_beat_cnt, w_beat_cnt;
    logic [IW-1:0]   r_rr_ptr,   w_rr_ptr;

    logic            w_cur_valid;
    logic            w_beat;
    logic            w_rearb;
    logic            w_found;
    logic [IW-1:0]   w_pick;

    // One search serves both the idle grant and the same-cycle handover.
    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req_valid),
        .start (r_rr_ptr),
        .found (w_found),
        .idx   (w_pick)
    );

    assign gnt_active  = (r_state == BURST);
    assign gnt_id      = r_gnt_id;
    assign w_cur_valid = req_valid[r_gnt_id];
    assign w_beat      = gnt_active & w_cur_valid & ~wfull;
    assign winc        = w_beat;

    always_comb begin
        req_ready = '0;
        wdata     = '0;
        if (gnt_active) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_gnt_id == IW'(i)) begin
                    req_ready[i] = ~wfull;
                    wdata        = req_data[i*DSIZE +: DSIZE];
                end
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_gnt_id   = r_gnt_id;
        w_beat_cnt = r_beat_cnt;
        w_rr_ptr   = r_rr_ptr;
        w_rearb    = 1'b0;

        case (r_state)
            IDLE: w_rearb = 1'b1;
            BURST: begin
                if (w_beat) begin
                    w_beat_cnt = r_beat_cnt + 1'b1;
                end
                // wfull stalls the beat but never ends the grant.
                w_rearb = (w_beat && (r_beat_cnt == LAST_BEAT)) || !w_cur_valid;
            end
            default: w_state = IDLE;
        endcase

        if (w_rearb) begin
            w_beat_cnt = '0;
            if (w_found) begin
                w_state  = BURST;
                w_gnt_id = w_pick;
                w_rr_ptr = (w_pick == LAST_ID) ? '0 : w_pick + 1'b1;
            end else begin
                w_state  = IDLE;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= IDLE;
            r_gnt_id   <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state;
            r_gnt_id   <= w_gnt_id;
            r_beat_cnt <= w_beat_cnt;
            r_rr_ptr   <= w_rr_ptr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Self-checking bench for fifo_wr_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst_n = 1'b0;
    logic                  wfull = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  gnt_active;
    logic [1:0]            gnt_id;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .gnt_active (gnt_active),
        .gnt_id     (gnt_id)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the grant, beats served in it, next priority.
    int m_active, m_gnt, m_beats, m_ptr;
    int acc_id;
    int src_seq  [NREQ];
    int src_left [NREQ];
    int src_base [NREQ];
    bit rnd_mode = 1'b0;
    logic [5:0] sb_seq [NREQ];
    logic [DSIZE-1:0] wr_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_gnt    = 0;
        m_beats  = 0;
        m_ptr    = 0;
        acc_id   = -1;
    endtask

    task automatic model_pick();
        m_active = 0;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (req_valid[c]) begin
                m_active = 1;
                m_gnt    = c;
                m_beats  = 0;
                m_ptr    = (c + 1) % NREQ;
                return;
            end
        end
    endtask

    task automatic model_update();
        bit v, b;
        acc_id = -1;
        if (!wrst_n) begin
            model_reset();
            return;
        end
        if (m_active == 0) begin
            model_pick();
        end else begin
            v = req_valid[m_gnt];
            b = v && !wfull;
            if (b) begin
                m_beats++;
                acc_id = m_gnt;
            end
            if ((b && m_beats == MAX_BURST) || !v) model_pick();
        end
        if (acc_id >= 0) begin
            src_seq[acc_id]++;
            src_left[acc_id]--;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (rnd_mode) begin
                if (i == acc_id || !req_valid[i]) req_valid[i] = 1'($urandom_range(0, 1));
                req_data[i*DSIZE +: DSIZE] = {2'(i), 6'(src_seq[i])};
            end else begin
                req_valid[i] = (src_left[i] > 0);
                req_data[i*DSIZE +: DSIZE] = 8'(src_base[i] + src_seq[i]);
            end
        end
    endtask

    task automatic compare_outputs();
        logic [NREQ-1:0]  e_ready;
        logic [DSIZE-1:0] e_data;
        logic             e_winc;
        logic [1:0]       id;
        if (!wrst_n) model_reset();
        e_ready = '0;
        e_data  = '0;
        e_winc  = 1'b0;
        if (m_active != 0) begin
            if (!wfull) e_ready[m_gnt] = 1'b1;
            e_data = req_data[m_gnt*DSIZE +: DSIZE];
            e_winc = req_valid[m_gnt] & ~wfull;
        end
        check_val("gnt_active", gnt_active, m_active);
        check_val("gnt_id", gnt_id, m_gnt);
        check_val("winc", winc, e_winc);
        check_val("req_ready", req_ready, e_ready);
        check_val("wdata", wdata, e_data);
        check_val("winc_and_wfull", winc & wfull, 0);
        if (winc === 1'b1) begin
            wr_q.push_back(wdata);
            if (rnd_mode) begin
                id = wdata[7:6];
                check_val("order", wdata[5:0], sb_seq[id]);
                sb_seq[id]++;
            end
        end
    endtask

    task automatic tick();
        #3;
        compare_outputs();
        @(posedge wclk);
        model_update();
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            src_seq[i]  = 0;
            src_left[i] = 0;
            src_base[i] = 0;
            sb_seq[i]   = '0;
        end
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        wfull  = 1'b0;
        rnd_mode = 1'b0;
        clear_sources();
        apply_inputs();
        tick();
        tick();
        wrst_n = 1'b1;
        wr_q.delete();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            apply_inputs();
            tick();
        end
    endtask

    initial begin
        model_reset();
        clear_sources();
        @(posedge wclk);
        #1;

        // Sole requester: burst of four, no-bubble regrant, two more beats.
        do_reset();
        src_base[0] = 'hA0;
        src_left[0] = 6;
        run(12);
        check_val("t1_len", wr_q.size(), 6);
        for (int k = 0; k < 6; k++) check_val("t1_data", wr_q[k], 'hA0 + k);

        // All valid: grants rotate 0,1,2,3,0 with four beats each.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            src_base[i] = i * 16;
            src_left[i] = 1000;
        end
        run(21);
        check_val("t2_len", wr_q.size(), 20);
        for (int k = 0; k < 20; k++)
            check_val("t2_data", wr_q[k], 16 * ((k / 4) % 4) + 4 * (k / 16) + (k % 4));

        // Requester 2 alone with a full FIFO mid-burst.
        do_reset();
        src_base[2] = 'h50;
        src_left[2] = 4;
        for (int c = 0; c < 15; c++) begin
            wfull = (c >= 3 && c <= 6);
            apply_inputs();
            tick();
        end
        wfull = 1'b0;
        check_val("t3_len", wr_q.size(), 4);
        for (int k = 0; k < 4; k++) check_val("t3_data", wr_q[k], 'h50 + k);

        // Requester 1 drops after two beats; 3 takes over; priority then returns to 0.
        do_reset();
        src_base[1] = 'h10; src_left[1] = 2;
        src_base[3] = 'h30; src_left[3] = 3;
        run(10);
        src_base[0] = 'h00; src_left[0] = 1;
        src_base[2] = 'h20; src_left[2] = 1;
        run(6);
        check_val("t4_len", wr_q.size(), 7);
        check_val("t4_d0", wr_q[0], 'h10);
        check_val("t4_d1", wr_q[1], 'h11);
        check_val("t4_d2", wr_q[2], 'h30);
        check_val("t4_d4", wr_q[4], 'h32);
        check_val("t4_d5", wr_q[5], 'h00);
        check_val("t4_d6", wr_q[6], 'h20);

        // Reset pulse in the middle of a burst.
        do_reset();
        src_base[0] = 'h70;
        src_left[0] = 10;
        run(3);
        wrst_n = 1'b0;
        #1;
        check_val("t5_winc", winc, 0);
        check_val("t5_active", gnt_active, 0);
        check_val("t5_ready", req_ready, 0);
        src_base[2] = 'h20;
        src_left[2] = 1;
        run(2);
        wrst_n = 1'b1;
        run(2);
        check_val("t5_restart", gnt_id, 0);
        check_val("t5_beats", wr_q.size(), 3);
        run(10);

        // Random traffic and backpressure with per-requester ordering scoreboard.
        do_reset();
        rnd_mode = 1'b1;
        repeat (10000) begin
            wfull = ($urandom_range(0, 3) == 0);
            apply_inputs();
            tick();
        end
        check_val("t6_progress", (wr_q.size() > 1000) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
